// File: rtl/mac_pkg.sv
// Shared sizing helpers and result-range constants for the multi-lane MAC.
package mac_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // Two guard bits above the larger of the dot-product and psum widths keep the
  // accumulate free of internal overflow in both signed and unsigned modes.
  function automatic int unsigned mac_width(input int unsigned in_bw,
                                            input int unsigned out_bw,
                                            input int unsigned lanes);
    int unsigned prod_w;
    prod_w = 2 * in_bw + clog2(lanes);
    return ((prod_w > out_bw) ? prod_w : out_bw) + 2;
  endfunction

  function automatic logic [63:0] sat_smax(input int unsigned out_bw);
    return (64'd1 << (out_bw - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_smin(input int unsigned out_bw);
    return 64'd1 << (out_bw - 1);
  endfunction

  function automatic logic [63:0] sat_umax(input int unsigned out_bw);
    return (out_bw >= 64) ? '1 : (64'd1 << out_bw) - 64'd1;
  endfunction

endpackage

// File: rtl/mac_sat.sv
// Combinational narrowing of the wide accumulator to the psum width, with
// clamp-or-wrap on overflow and an overflow flag.
module mac_sat
  import mac_pkg::*;
#(
  parameter int unsigned W            = 20,
  parameter int unsigned OUT_BITWIDTH = 16
) (
  input  logic [W-1:0]            val,
  input  logic                    signed_mode,
  input  logic                    sat_en,
  output logic [OUT_BITWIDTH-1:0] res,
  output logic                    ovf
);

  localparam logic [63:0] SMAX_L = sat_smax(OUT_BITWIDTH);
  localparam logic [63:0] SMIN_L = sat_smin(OUT_BITWIDTH);
  localparam logic [63:0] UMAX_L = sat_umax(OUT_BITWIDTH);
  localparam logic [OUT_BITWIDTH-1:0] SMAX = SMAX_L[OUT_BITWIDTH-1:0];
  localparam logic [OUT_BITWIDTH-1:0] SMIN = SMIN_L[OUT_BITWIDTH-1:0];
  localparam logic [OUT_BITWIDTH-1:0] UMAX = UMAX_L[OUT_BITWIDTH-1:0];

  logic [OUT_BITWIDTH-1:0] clamp;

  always_comb begin
    clamp = '0;
    ovf   = 1'b0;
    if (signed_mode) begin
      // In range only when every bit from the result sign upward agrees.
      ovf   = !((&val[W-1:OUT_BITWIDTH-1]) || !(|val[W-1:OUT_BITWIDTH-1]));
      clamp = val[W-1] ? SMIN : SMAX;
    end else begin
      ovf   = |val[W-1:OUT_BITWIDTH];
      clamp = val[W-1] ? '0 : UMAX;
    end
    res = (ovf && sat_en) ? clamp : val[OUT_BITWIDTH-1:0];
  end

endmodule

// File: rtl/mac_pipe_lanes.sv
// Two-stage, LANES-wide multiply-accumulate with psum address tracking and
// distance-1/distance-2 result forwarding for back-to-back same-address ops.
module mac_pipe_lanes
  import mac_pkg::*;
#(
  parameter int unsigned IN_BITWIDTH        = 8,
  parameter int unsigned OUT_BITWIDTH       = 16,
  parameter int unsigned PSUM_ADDR_BITWIDTH = 2,
  parameter int unsigned LANES              = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  input  logic                                signed_mode,
  input  logic                                sat_en,
  input  logic                                fwd_en,
  input  logic [LANES*IN_BITWIDTH-1:0]        a_in,
  input  logic [LANES*IN_BITWIDTH-1:0]        w_in,
  input  logic [OUT_BITWIDTH-1:0]             sum_in,
  input  logic [PSUM_ADDR_BITWIDTH-1:0]       psum_write_addr,
  output logic [OUT_BITWIDTH-1:0]             out,
  output logic [PSUM_ADDR_BITWIDTH-1:0]       write_addr,
  output logic                                out_en,
  output logic                                ovf
);

  localparam int unsigned PW = 2 * IN_BITWIDTH;
  localparam int unsigned W  = mac_width(IN_BITWIDTH, OUT_BITWIDTH, LANES);

  logic [LANES*PW-1:0]           prod_flat;
  logic [LANES*PW-1:0]           s1_prod;
  logic [OUT_BITWIDTH-1:0]       s1_sum;
  logic [PSUM_ADDR_BITWIDTH-1:0] s1_addr;
  logic                          s1_signed, s1_sat, s1_fwd, s1_valid;

  logic [OUT_BITWIDTH-1:0]       ret_val;
  logic [PSUM_ADDR_BITWIDTH-1:0] ret_addr;
  logic                          ret_valid;

  logic [OUT_BITWIDTH-1:0]       addend;
  logic [W-1:0]                  acc;
  logic [PW-1:0]                 lane_p;
  logic [OUT_BITWIDTH-1:0]       sat_val;
  logic                          sat_ovf;

  // Operands are extended per mode to 2*IN bits; the low 2*IN bits of the
  // product are then exact for both signed and unsigned interpretations.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [PW-1:0] a_ext, w_ext;
    assign a_ext = signed_mode
        ? {{IN_BITWIDTH{a_in[g*IN_BITWIDTH+IN_BITWIDTH-1]}}, a_in[g*IN_BITWIDTH +: IN_BITWIDTH]}
        : {{IN_BITWIDTH{1'b0}}, a_in[g*IN_BITWIDTH +: IN_BITWIDTH]};
    assign w_ext = signed_mode
        ? {{IN_BITWIDTH{w_in[g*IN_BITWIDTH+IN_BITWIDTH-1]}}, w_in[g*IN_BITWIDTH +: IN_BITWIDTH]}
        : {{IN_BITWIDTH{1'b0}}, w_in[g*IN_BITWIDTH +: IN_BITWIDTH]};
    assign prod_flat[g*PW +: PW] = a_ext * w_ext;
  end

  always_comb begin
    addend = s1_sum;
    if (s1_fwd && s1_valid && out_en && (write_addr == s1_addr))
      addend = out;
    else if (s1_fwd && s1_valid && ret_valid && (ret_addr == s1_addr))
      addend = ret_val;

    acc = s1_signed ? {{(W-OUT_BITWIDTH){addend[OUT_BITWIDTH-1]}}, addend}
                    : {{(W-OUT_BITWIDTH){1'b0}}, addend};
    lane_p = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_p = s1_prod[i*PW +: PW];
      acc = acc + (s1_signed ? {{(W-PW){lane_p[PW-1]}}, lane_p}
                             : {{(W-PW){1'b0}}, lane_p});
    end
  end

  mac_sat #(
    .W            (W),
    .OUT_BITWIDTH (OUT_BITWIDTH)
  ) u_sat (
    .val         (acc),
    .signed_mode (s1_signed),
    .sat_en      (s1_sat),
    .res         (sat_val),
    .ovf         (sat_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_prod    <= '0;
      s1_sum     <= '0;
      s1_addr    <= '0;
      s1_signed  <= 1'b0;
      s1_sat     <= 1'b0;
      s1_fwd     <= 1'b0;
      s1_valid   <= 1'b0;
      ret_val    <= '0;
      ret_addr   <= '0;
      ret_valid  <= 1'b0;
      out        <= '0;
      write_addr <= '0;
      out_en     <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      s1_valid <= en;
      if (en) begin
        s1_prod   <= prod_flat;
        s1_sum    <= sum_in;
        s1_addr   <= psum_write_addr;
        s1_signed <= signed_mode;
        s1_sat    <= sat_en;
        s1_fwd    <= fwd_en;
      end
      ret_val   <= out;
      ret_addr  <= write_addr;
      ret_valid <= out_en;
      out_en    <= s1_valid;
      if (s1_valid) begin
        out        <= sat_val;
        ovf        <= sat_ovf;
        write_addr <= s1_addr;
      end else begin
        out <= '0;
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_pipe_lanes.sv
// Directed bench for mac_pipe_lanes: vector table for single ops plus
// hand-written forwarding, bubble and reset sequences.
module tb_mac_pipe_lanes;

  localparam int unsigned IN_BW = 8;
  localparam int unsigned OUT_BW = 16;
  localparam int unsigned AW = 2;
  localparam int unsigned LANES = 4;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      en = 1'b0;
  logic                      signed_mode = 1'b0;
  logic                      sat_en = 1'b0;
  logic                      fwd_en = 1'b0;
  logic [LANES*IN_BW-1:0]    a_in = '0;
  logic [LANES*IN_BW-1:0]    w_in = '0;
  logic [OUT_BW-1:0]         sum_in = '0;
  logic [AW-1:0]             psum_write_addr = '0;
  logic [OUT_BW-1:0]         out;
  logic [AW-1:0]             write_addr;
  logic                      out_en;
  logic                      ovf;

  int n_tests = 0;
  int n_fail  = 0;

  mac_pipe_lanes #(
    .IN_BITWIDTH        (IN_BW),
    .OUT_BITWIDTH       (OUT_BW),
    .PSUM_ADDR_BITWIDTH (AW),
    .LANES              (LANES)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .signed_mode     (signed_mode),
    .sat_en          (sat_en),
    .fwd_en          (fwd_en),
    .a_in            (a_in),
    .w_in            (w_in),
    .sum_in          (sum_in),
    .psum_write_addr (psum_write_addr),
    .out             (out),
    .write_addr      (write_addr),
    .out_en          (out_en),
    .ovf             (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] w;
    logic [15:0] sum;
    logic [1:0]  addr;
    logic        sg;
    logic        st;
    logic [15:0] exp_out;
    logic        exp_ovf;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input logic [31:0] a, input logic [31:0] w,
                         input logic [15:0] sum, input logic [1:0] addr, input logic sg,
                         input logic st, input logic [15:0] exp_out, input logic exp_ovf);
    vec_t v;
    v.name = name; v.a = a; v.w = w; v.sum = sum; v.addr = addr;
    v.sg = sg; v.st = st; v.exp_out = exp_out; v.exp_ovf = exp_ovf;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] w, input logic [15:0] s,
                       input logic [1:0] ad, input logic sg, input logic st, input logic fw);
    en = 1'b1; a_in = a; w_in = w; sum_in = s; psum_write_addr = ad;
    signed_mode = sg; sat_en = st; fwd_en = fw;
  endtask

  task automatic idle();
    en = 1'b0;
  endtask

  logic [15:0] fwd_exp [3];

  initial begin
    add_vec("u_dot",      32'h04030201, 32'h08070605, 16'd10,   2'd2, 1'b0, 1'b0, 16'd80,   1'b0);
    add_vec("s_dot",      32'h000000FD, 32'h00000004, 16'hFFFB, 2'd1, 1'b1, 1'b1, 16'hFFEF, 1'b0);
    add_vec("u_sat",      32'hFFFFFFFF, 32'hFFFFFFFF, 16'hFFFF, 2'd0, 1'b0, 1'b1, 16'hFFFF, 1'b1);
    add_vec("u_wrap",     32'hFFFFFFFF, 32'hFFFFFFFF, 16'hFFFF, 2'd0, 1'b0, 1'b0, 16'hF803, 1'b1);
    add_vec("s_sat_pos",  32'h80808080, 32'h80808080, 16'h0000, 2'd3, 1'b1, 1'b1, 16'h7FFF, 1'b1);
    add_vec("s_wrap_pos", 32'h80808080, 32'h80808080, 16'h0000, 2'd3, 1'b1, 1'b0, 16'h0000, 1'b1);
    add_vec("s_sat_neg",  32'h80808080, 32'h7F7F7F7F, 16'h8000, 2'd2, 1'b1, 1'b1, 16'h8000, 1'b1);
    add_vec("s_wrap_neg", 32'h80808080, 32'h7F7F7F7F, 16'h8000, 2'd2, 1'b1, 1'b0, 16'h8200, 1'b1);
    add_vec("s_max_edge", 32'h00000000, 32'h00000000, 16'h7FFF, 2'd1, 1'b1, 1'b1, 16'h7FFF, 1'b0);
    add_vec("u_max_edge", 32'h00000000, 32'h00000000, 16'hFFFF, 2'd1, 1'b0, 1'b1, 16'hFFFF, 1'b0);
    add_vec("u_128",      32'h00000080, 32'h00000002, 16'h0000, 2'd0, 1'b0, 1'b0, 16'h0100, 1'b0);
    add_vec("s_128",      32'h00000080, 32'h00000002, 16'h0000, 2'd0, 1'b1, 1'b0, 16'hFF00, 1'b0);
    add_vec("s_min_edge", 32'h00000080, 32'h0000007F, 16'hBF80, 2'd3, 1'b1, 1'b1, 16'h8000, 1'b0);
    add_vec("s_under_1",  32'h00000080, 32'h0000007F, 16'hBF7F, 2'd3, 1'b1, 1'b1, 16'h8000, 1'b1);

    // Reset state
    #2;
    check("rst.out", out, 0);
    check("rst.out_en", out_en, 0);
    check("rst.ovf", ovf, 0);
    check("rst.write_addr", write_addr, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-op vectors: result two cycles after issue, valid for exactly one cycle
    foreach (vecs[i]) begin
      @(negedge clk);
      issue(vecs[i].a, vecs[i].w, vecs[i].sum, vecs[i].addr, vecs[i].sg, vecs[i].st, 1'b0);
      @(negedge clk);
      idle();
      check($sformatf("%s.early_en", vecs[i].name), out_en, 0);
      @(negedge clk);
      check($sformatf("%s.out", vecs[i].name), out, vecs[i].exp_out);
      check($sformatf("%s.ovf", vecs[i].name), ovf, vecs[i].exp_ovf);
      check($sformatf("%s.out_en", vecs[i].name), out_en, 1);
      check($sformatf("%s.addr", vecs[i].name), write_addr, vecs[i].addr);
      @(negedge clk);
      check($sformatf("%s.drop_en", vecs[i].name), out_en, 0);
      check($sformatf("%s.idle_out", vecs[i].name), out, 0);
    end

    // Back-to-back same address, forwarding on then off
    for (int unsigned pass = 0; pass < 2; pass++) begin
      fwd_exp[0] = 16'd1;
      fwd_exp[1] = (pass == 0) ? 16'd2 : 16'd1;
      fwd_exp[2] = (pass == 0) ? 16'd3 : 16'd1;
      @(negedge clk);
      for (int unsigned cyc = 0; cyc < 5; cyc++) begin
        if (cyc >= 2) begin
          check($sformatf("fwd%0d.out%0d", pass, cyc - 2), out, fwd_exp[cyc-2]);
          check($sformatf("fwd%0d.en%0d", pass, cyc - 2), out_en, 1);
        end
        if (cyc < 3) issue(32'h1, 32'h1, 16'd0, 2'd1, 1'b0, 1'b0, (pass == 0));
        else idle();
        @(negedge clk);
      end
      check($sformatf("fwd%0d.tail_en", pass), out_en, 0);
    end

    // Different address does not forward
    @(negedge clk);
    issue(32'h1, 32'h5, 16'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    issue(32'h0, 32'h0, 16'd7, 2'd1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    idle();
    check("nofwd.first", out, 5);
    @(negedge clk);
    check("nofwd.second", out, 7);
    check("nofwd.addr", write_addr, 1);
    @(negedge clk);

    // Distance 2 via retired register, with bubble between
    for (int unsigned pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      issue(32'h2, 32'h3, 16'd4, 2'd3, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      idle();
      @(negedge clk);
      check($sformatf("d2_%0d.first", pass), out, 10);
      issue(32'h1, 32'h1, 16'd100, 2'd3, 1'b0, 1'b0, (pass == 0));
      @(negedge clk);
      idle();
      check($sformatf("d2_%0d.bubble_en", pass), out_en, 0);
      check($sformatf("d2_%0d.bubble_addr", pass), write_addr, 3);
      @(negedge clk);
      check($sformatf("d2_%0d.second", pass), out, (pass == 0) ? 11 : 101);
      check($sformatf("d2_%0d.second_en", pass), out_en, 1);
      @(negedge clk);
    end

    // Reset with two ops in flight
    @(negedge clk);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 16'hFFFF, 2'd3, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 16'hFFFF, 2'd2, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    idle();
    check("rstmid.pre_en", out_en, 1);
    check("rstmid.pre_ovf", ovf, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstmid.out", out, 0);
    check("rstmid.out_en", out_en, 0);
    check("rstmid.ovf", ovf, 0);
    check("rstmid.addr", write_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("rstmid.quiet%0d", c), out_en, 0);
    end
    issue(32'h04030201, 32'h08070605, 16'd10, 2'd2, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    idle();
    @(negedge clk);
    check("rstmid.new_out", out, 80);
    check("rstmid.new_en", out_en, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
